autoshift_reg: RTL and testbench
================================

AUTOSHIFT_REG -- requirements
Module: autoshift_reg

Interface
REQ-001 Parameter WIDTH, default 32: shift register width; legal 8..32.
REQ-002 Parameter MODE, default 0: 0 = input shifter (ISR, autopush); 1 = output shifter (OSR, autopull).
REQ-003 Parameter CW, default $clog2(WIDTH): shift/threshold field width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 penable  input  1  clock-divider enable; state advances only when high.
REQ-007 dir  input  1  0 = shift left (MSB first); 1 = shift right (LSB first).
REQ-008 auto_en  input  1  enables autopush (MODE 0) or autopull (MODE 1).
REQ-009 threshold  input  CW  auto threshold; 0 encodes WIDTH.
REQ-010 shift_req  input  1  perform a shift of shift_cnt bits.
REQ-011 shift_cnt  input  CW  bit count; 0 encodes WIDTH.
REQ-012 shift_din  input  WIDTH  MODE 0 source bits, taken from shift_din[n-1:0].
REQ-013 load  input  1  load load_din into the register; count := 0.
REQ-014 load_din  input  WIDTH  parallel load value.
REQ-015 fifo_req  input  1  explicit push (MODE 0) or pull (MODE 1).
REQ-016 block  input  1  explicit request stalls when FIFO is not ready.
REQ-017 fifo_ok  input  1  MODE 0: FIFO not full; MODE 1: FIFO not empty.
REQ-018 fifo_din  input  WIDTH  pull data (MODE 1).
REQ-019 fifo_strobe  output  1  one-cycle push/pull pulse.
REQ-020 fifo_dout  output  WIDTH  push data; valid while fifo_strobe is high.
REQ-021 shift_out  output  WIDTH  MODE 1 shifted-out bits, right-justified, zero-extended; registered.
REQ-022 dout  output  WIDTH  current register value.
REQ-023 count  output  CW+1  bits shifted since last load/push/pull; saturates at WIDTH.
REQ-024 stall  output  1  high while an auto or blocking transfer is pending.

Function
REQ-025 Per penable cycle, at most one action; priority: load > fifo_req > shift_req; lower-priority requests are dropped.
REQ-026 MODE 0 shift, n bits: left: reg := (reg<<n)|din[n-1:0]; right: reg := (reg>>n)|(din[n-1:0]<<(WIDTH-n)).
REQ-027 MODE 1 shift, n bits: shift_out := top n bits (left) or bottom n bits (right); reg shifts zero-filled.
REQ-028 count := min(count+n, WIDTH) on every shift.
REQ-029 FSM states: READY, PENDING. READY -> PENDING when an auto shift leaves count >= threshold, or on a blocking fifo_req with fifo_ok low.
REQ-030 In PENDING: stall = 1; all requests are ignored; the transfer is retried every penable cycle.
REQ-031 Transfer when fifo_ok: fifo_strobe = 1 for one clk. MODE 0: fifo_dout = reg, then reg := 0. MODE 1: reg := fifo_din. In both modes count := 0, then go to READY.
REQ-032 fifo_req in READY with fifo_ok high transfers in the same cycle; with fifo_ok and block both low it is a no-op. In MODE 1 that no-op loads nothing.
REQ-033 A shift that reaches threshold exactly triggers auto transfer; n = WIDTH shifts the full register.
REQ-034 fifo_strobe never asserts when penable is low.

Reset
REQ-035 On reset: reg = 0, shift_out = 0, fifo_strobe = 0, stall = 0, state = READY.
REQ-036 Reset count value: 0 in MODE 0; WIDTH in MODE 1, so the OSR starts empty.
REQ-037 Reset during PENDING abandons the transfer with no strobe.

Configuration
REQ-038 Macro AUTOSHIFT_AUTO_EN defined: auto transfer per REQ-029 to REQ-033 when auto_en is high.
REQ-039 Macro absent: auto_en is ignored; PENDING is entered only by a blocking fifo_req; count still saturates.

Verification
REQ-040 MODE 0, left, auto, threshold 8: four shifts of 2 bits with din = 3 -> strobe on 4th-shift follow-up, fifo_dout = 0x000000FF, count = 0.
REQ-041 MODE 0, auto, fifo_ok = 0 at threshold -> stall held 5 cycles, other shift_req ignored; fifo_ok = 1 -> single strobe, stall = 0.
REQ-042 MODE 1, after reset, auto, fifo_din = 0xA5000000, left, shift 8 -> pull first, then shift_out = 0xA5, count = 8.
REQ-043 MODE 1, right, reg loaded with 0x12345678, shift_cnt = 0 -> shift_out = 0x12345678, reg = 0, count = 32.
REQ-044 load and fifo_req in the same cycle -> reg = load_din, no strobe.
REQ-045 Reset asserted in PENDING -> next cycle stall = 0, no strobe, count matches REQ-036.

Source files
------------

// File: rtl/autoshift_reg_if.sv
// FIFO-side handshake of the autoshift register: push/pull strobe plus data in both directions.
interface autoshift_reg_if #(
    parameter int WIDTH = 32
);
    logic             fifo_strobe;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_ok;
    logic [WIDTH-1:0] fifo_din;

    modport master (output fifo_strobe, fifo_dout, input fifo_ok, fifo_din);
    modport slave  (input fifo_strobe, fifo_dout, output fifo_ok, fifo_din);
endinterface

// File: rtl/autoshift_reg.sv
// Input/output shift register with explicit and automatic FIFO push/pull (PIO-style ISR/OSR).
// Define AUTOSHIFT_AUTO_EN to enable autopush/autopull driven by auto_en and threshold.
module autoshift_reg #(
    parameter int WIDTH = 32,
    parameter int MODE  = 0,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             penable,
    input  logic             dir,
    input  logic             auto_en,
    input  logic [CW-1:0]    threshold,
    input  logic             shift_req,
    input  logic [CW-1:0]    shift_cnt,
    input  logic [WIDTH-1:0] shift_din,
    input  logic             load,
    input  logic [WIDTH-1:0] load_din,
    input  logic             fifo_req,
    input  logic             block,
    autoshift_reg_if.master  fifo,
    output logic [WIDTH-1:0] shift_out,
    output logic [WIDTH-1:0] dout,
    output logic [CW:0]      count,
    output logic             stall
);
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] WFULL = CW1'(WIDTH);

    typedef enum logic {READY, PENDING} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sr, sr_nx, sout_nx;
    logic [CW:0]      cnt, cnt_nx, cnt_sh, n, rem;
    logic [CW+1:0]    cnt_sum;
    logic [WIDTH-1:0] mask, din_m, sh_reg, sh_out;
    logic             xfer, auto_pre, auto_post;
    logic             unused_in;

    // Zero encodes a full-width count; oversized codes clamp to WIDTH.
    function automatic logic [CW:0] decode(input logic [CW-1:0] v);
        logic [CW:0] d;
        d = (v == '0) ? WFULL : {1'b0, v};
        return (d > WFULL) ? WFULL : d;
    endfunction

    assign n       = decode(shift_cnt);
    assign rem     = WFULL - n;
    assign mask    = {WIDTH{1'b1}} >> rem;
    assign din_m   = shift_din & mask;
    assign cnt_sum = {1'b0, cnt} + {1'b0, n};
    assign cnt_sh  = (cnt_sum > {1'b0, WFULL}) ? WFULL : cnt_sum[CW:0];

    always_comb begin
        sh_reg = dir ? (sr >> n) : (sr << n);
        sh_out = '0;
        if (MODE == 0)
            sh_reg = sh_reg | (dir ? (din_m << rem) : din_m);
        else
            sh_out = dir ? (sr & mask) : (sr >> rem);
    end

`ifdef AUTOSHIFT_AUTO_EN
    logic [CW:0] thr;
    assign thr       = decode(threshold);
    // OSR refills before shifting when already drained; ISR flushes after filling.
    assign auto_pre  = (MODE == 1) && auto_en && (cnt >= thr);
    assign auto_post = auto_en && (cnt_sh >= thr);
`else
    logic unused_auto;
    assign unused_auto = auto_en ^ (^threshold);
    assign auto_pre    = 1'b0;
    assign auto_post   = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        sout_nx  = shift_out;
        cnt_nx   = cnt;
        xfer     = 1'b0;
        if (penable) begin
            if (state == PENDING) begin
                xfer = fifo.fifo_ok;
            end else if (load) begin
                sr_nx  = load_din;
                cnt_nx = '0;
            end else if (fifo_req) begin
                if (fifo.fifo_ok)
                    xfer = 1'b1;
                else if (block)
                    state_nx = PENDING;
            end else if (shift_req) begin
                if (auto_pre) begin
                    state_nx = PENDING;
                end else begin
                    sr_nx  = sh_reg;
                    cnt_nx = cnt_sh;
                    if (MODE == 1) sout_nx = sh_out;
                    if (auto_post) state_nx = PENDING;
                end
            end
            if (xfer) begin
                sr_nx    = (MODE == 0) ? '0 : fifo.fifo_din;
                cnt_nx   = '0;
                state_nx = READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= READY;
            sr        <= '0;
            shift_out <= '0;
            cnt       <= (MODE == 1) ? WFULL : '0;
        end else begin
            state     <= state_nx;
            sr        <= sr_nx;
            shift_out <= sout_nx;
            cnt       <= cnt_nx;
        end
    end

    assign fifo.fifo_strobe = xfer & ~reset;
    assign fifo.fifo_dout   = sr;
    assign dout             = sr;
    assign count            = cnt;
    assign stall            = (state == PENDING);
    assign unused_in        = ^{fifo.fifo_din, shift_din};
endmodule

// File: tb/tb_autoshift_reg.sv
// Directed bench for autoshift_reg: one ISR and one OSR instance on shared stimulus, strobe scoreboard per FIFO.
module tb_autoshift_reg;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, penable, dir, auto_en, shift_req, load, fifo_req, block;
  logic [4:0] threshold, shift_cnt;
  logic [W-1:0] shift_din, load_din;
  logic [W-1:0] shift_out0, dout0, shift_out1, dout1;
  logic [5:0] count0, count1;
  logic stall0, stall1;

  autoshift_reg_if #(.WIDTH(W)) f0 ();
  autoshift_reg_if #(.WIDTH(W)) f1 ();

  autoshift_reg #(.WIDTH(W), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .penable(penable), .dir(dir), .auto_en(auto_en),
    .threshold(threshold), .shift_req(shift_req), .shift_cnt(shift_cnt), .shift_din(shift_din),
    .load(load), .load_din(load_din), .fifo_req(fifo_req), .block(block), .fifo(f0),
    .shift_out(shift_out0), .dout(dout0), .count(count0), .stall(stall0));

  autoshift_reg #(.WIDTH(W), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .penable(penable), .dir(dir), .auto_en(auto_en),
    .threshold(threshold), .shift_req(shift_req), .shift_cnt(shift_cnt), .shift_din(shift_din),
    .load(load), .load_din(load_din), .fifo_req(fifo_req), .block(block), .fifo(f1),
    .shift_out(shift_out1), .dout(dout1), .count(count1), .stall(stall1));

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard strobes on the falling edge, then step past the rising edge.
  task automatic cyc();
    logic e;
    logic [31:0] x;
    @(negedge clk);
    e = (q0.size() != 0);
    chk("strobe0", 32'(f0.fifo_strobe), 32'(e));
    if (e) begin
      x = q0.pop_front();
      if (f0.fifo_strobe === 1'b1) chk("fifo_dout0", f0.fifo_dout, x);
    end
    e = (q1.size() != 0);
    chk("strobe1", 32'(f1.fifo_strobe), 32'(e));
    if (e) begin
      x = q1.pop_front();
      if (f1.fifo_strobe === 1'b1) chk("fifo_dout1", f1.fifo_dout, x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic s0(input string tag, input logic [31:0] d, input logic [5:0] c, input logic s);
    chk({tag, ".dout0"}, dout0, d);
    chk({tag, ".count0"}, 32'(count0), 32'(c));
    chk({tag, ".stall0"}, 32'(stall0), 32'(s));
  endtask

  task automatic s1(input string tag, input logic [31:0] so, input logic [31:0] d,
                    input logic [5:0] c, input logic s);
    chk({tag, ".shift_out1"}, shift_out1, so);
    chk({tag, ".dout1"}, dout1, d);
    chk({tag, ".count1"}, 32'(count1), 32'(c));
    chk({tag, ".stall1"}, 32'(stall1), 32'(s));
  endtask

  initial begin
    reset = 1'b1; penable = 1'b1; dir = 1'b0; auto_en = 1'b0; threshold = 5'd0;
    shift_req = 1'b0; shift_cnt = 5'd0; shift_din = '0; load = 1'b0; load_din = '0;
    fifo_req = 1'b0; block = 1'b0;
    f0.fifo_ok = 1'b0; f0.fifo_din = '0; f1.fifo_ok = 1'b0; f1.fifo_din = '0;
    #1;
    cyc(); cyc();
    s0("rst", 32'h0, 6'd0, 1'b0);
    chk("rst.shift_out0", shift_out0, 32'h0);
    s1("rst", 32'h0, 32'h0, 6'd32, 1'b0);
    reset = 1'b0;

    // ISR shifts: masking of din, both directions, full-width shift, saturation
    shift_req = 1'b1; shift_cnt = 5'd4; shift_din = 32'hFFFF_FFF5;
    cyc(); s0("a1", 32'h5, 6'd4, 1'b0);
    cyc(); s0("a1b", 32'h55, 6'd8, 1'b0);
    dir = 1'b1; shift_cnt = 5'd8; shift_din = 32'h1234_56AB;
    cyc(); s0("a2", 32'hAB00_0000, 6'd16, 1'b0);
    dir = 1'b0; shift_cnt = 5'd0; shift_din = 32'hDEAD_BEEF;
    cyc(); s0("a3", 32'hDEAD_BEEF, 6'd32, 1'b0);
    penable = 1'b0; shift_cnt = 5'd4;
    cyc(); s0("a4", 32'hDEAD_BEEF, 6'd32, 1'b0);
    penable = 1'b1; shift_req = 1'b0;

    // explicit push, load priority, non-blocking no-op, fifo_req over shift_req
    fifo_req = 1'b1; f0.fifo_ok = 1'b1; q0.push_back(32'hDEAD_BEEF);
    cyc(); s0("a5", 32'h0, 6'd0, 1'b0);
    load = 1'b1; load_din = 32'h1234_5678;
    cyc(); s0("a6", 32'h1234_5678, 6'd0, 1'b0);
    load = 1'b0; f0.fifo_ok = 1'b0;
    cyc(); s0("a7", 32'h1234_5678, 6'd0, 1'b0);
    f0.fifo_ok = 1'b1; shift_req = 1'b1; shift_cnt = 5'd4; q0.push_back(32'h1234_5678);
    cyc(); s0("a8", 32'h0, 6'd0, 1'b0);

    // blocking push while FIFO full: requests ignored, no strobe with penable low
    fifo_req = 1'b0; f0.fifo_ok = 1'b0; shift_cnt = 5'd8; shift_din = 32'h3C;
    cyc(); s0("a9", 32'h3C, 6'd8, 1'b0);
    shift_req = 1'b0; fifo_req = 1'b1; block = 1'b1;
    cyc(); s0("a9p", 32'h3C, 6'd8, 1'b1);
    fifo_req = 1'b0; load = 1'b1; load_din = 32'hFFFF; shift_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); s0("a9h", 32'h3C, 6'd8, 1'b1);
    end
    load = 1'b0; shift_req = 1'b0; penable = 1'b0; f0.fifo_ok = 1'b1;
    cyc(); s0("a9g", 32'h3C, 6'd8, 1'b1);
    penable = 1'b1; q0.push_back(32'h3C);
    cyc(); s0("a9x", 32'h0, 6'd0, 1'b0);

    // reset while pending abandons the push
    shift_req = 1'b1; block = 1'b0; f0.fifo_ok = 1'b0;
    cyc(); s0("a10s", 32'h3C, 6'd8, 1'b0);
    shift_req = 1'b0; fifo_req = 1'b1; block = 1'b1;
    cyc(); s0("a10p", 32'h3C, 6'd8, 1'b1);
    fifo_req = 1'b0; block = 1'b0; f0.fifo_ok = 1'b1; reset = 1'b1;
    cyc(); s0("a10r", 32'h0, 6'd0, 1'b0);
    reset = 1'b0; f0.fifo_ok = 1'b0;

    // autopush at threshold 8 with 2-bit shifts of 3
    auto_en = 1'b1; threshold = 5'd8; shift_cnt = 5'd2; shift_din = 32'h3; dir = 1'b0;
    f0.fifo_ok = 1'b1; shift_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc(); s0("b1", 32'((1 << (2 * i)) - 1), 6'(2 * i), 1'b0);
    end
`ifdef AUTOSHIFT_AUTO_EN
    cyc(); s0("b1t", 32'hFF, 6'd8, 1'b1);
    shift_req = 1'b0; q0.push_back(32'hFF);
    cyc(); s0("b1x", 32'h0, 6'd0, 1'b0);
    f0.fifo_ok = 1'b0; shift_req = 1'b1;
    cyc(); cyc(); cyc();
    cyc(); s0("b2t", 32'hFF, 6'd8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(); s0("b2h", 32'hFF, 6'd8, 1'b1);
    end
    shift_req = 1'b0; f0.fifo_ok = 1'b1; q0.push_back(32'hFF);
    cyc(); s0("b2x", 32'h0, 6'd0, 1'b0);
`else
    cyc(); s0("b1n", 32'hFF, 6'd8, 1'b0);
    cyc(); s0("b1m", 32'h3FF, 6'd10, 1'b0);
    shift_req = 1'b0;
`endif
    auto_en = 1'b0; f0.fifo_ok = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0;

    // OSR: first shift after reset needs a pull
    dir = 1'b0; shift_cnt = 5'd8; f1.fifo_din = 32'hA500_0000; f1.fifo_ok = 1'b1;
`ifdef AUTOSHIFT_AUTO_EN
    auto_en = 1'b1; threshold = 5'd0; shift_req = 1'b1;
    cyc(); s1("c1p", 32'h0, 32'h0, 6'd32, 1'b1);
    q1.push_back(32'h0);
    cyc(); s1("c1x", 32'h0, 32'hA500_0000, 6'd0, 1'b0);
    cyc(); s1("c1s", 32'hA5, 32'h0, 6'd8, 1'b0);
    shift_req = 1'b0; auto_en = 1'b0;
`else
    fifo_req = 1'b1; q1.push_back(32'h0);
    cyc(); s1("c1x", 32'h0, 32'hA500_0000, 6'd0, 1'b0);
    fifo_req = 1'b0; shift_req = 1'b1;
    cyc(); s1("c1s", 32'hA5, 32'h0, 6'd8, 1'b0);
    shift_req = 1'b0;
`endif

    // OSR full-width right shift, then partial shifts both ways
    f1.fifo_ok = 1'b0; load = 1'b1; load_din = 32'h1234_5678;
    cyc(); s1("c2l", 32'hA5, 32'h1234_5678, 6'd0, 1'b0);
    load = 1'b0; dir = 1'b1; shift_cnt = 5'd0; shift_req = 1'b1;
    cyc(); s1("c2", 32'h1234_5678, 32'h0, 6'd32, 1'b0);
    shift_req = 1'b0; load = 1'b1;
    cyc(); s1("c3l", 32'h1234_5678, 32'h1234_5678, 6'd0, 1'b0);
    load = 1'b0; shift_req = 1'b1; shift_cnt = 5'd4;
    cyc(); s1("c3r", 32'h8, 32'h0123_4567, 6'd4, 1'b0);
    dir = 1'b0; shift_cnt = 5'd8;
    cyc(); s1("c3s", 32'h01, 32'h2345_6700, 6'd12, 1'b0);
    shift_req = 1'b0;

    // non-blocking pull on empty FIFO loads nothing; then a real pull
    fifo_req = 1'b1; block = 1'b0; f1.fifo_din = 32'hFFFF_FFFF;
    cyc(); s1("c4", 32'h01, 32'h2345_6700, 6'd12, 1'b0);
    f1.fifo_ok = 1'b1; f1.fifo_din = 32'hCAFE_F00D; q1.push_back(32'h2345_6700);
    cyc(); s1("c5", 32'h01, 32'hCAFE_F00D, 6'd0, 1'b0);

    // reset while a blocking pull is pending: OSR returns empty
    f1.fifo_ok = 1'b0; block = 1'b1;
    cyc(); s1("c6p", 32'h01, 32'hCAFE_F00D, 6'd0, 1'b1);
    fifo_req = 1'b0; block = 1'b0; f1.fifo_ok = 1'b1; reset = 1'b1;
    cyc(); s1("c6r", 32'h0, 32'h0, 6'd32, 1'b0);
    reset = 1'b0; f1.fifo_ok = 1'b0;

    chk("sb_empty", 32'(q0.size() + q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
